// File: rtl/wb_pkg.sv
// Shared constants for the register-file writeback path (64 x 32 register file).
package wb_pkg;

    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 32;
    localparam int REG_COUNT = 64;
    localparam int ZERO_REG  = 0;

endpackage

// File: rtl/wb_fifo.sv
// In-order circular queue holding pending register writes; exposes its storage
// and per-slot valid mask so the top level can search pending destinations.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = wb_pkg::ADDR_W,
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [ADDR_W-1:0]         push_rd,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    output logic [ADDR_W-1:0]         head_rd,
    output logic [DATA_W-1:0]         head_data,
    output logic                      full,
    output logic                      empty,
    output logic [PTR_W-1:0]          wr_ptr,
    output logic [DEPTH-1:0]          valid_mask,
    output logic [DEPTH*ADDR_W-1:0]   entry_rd,
    output logic [DEPTH*DATA_W-1:0]   entry_data
);

    logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push_s;
    logic              do_pop_s;
    logic [PTR_W-1:0]  offset_s;

    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == {CNT_W{1'b0}});
    assign wr_ptr = wr_ptr_q;

    // Next pointer/count; a push and a pop on the same edge leave count unchanged.
    always_comb begin
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        rd_ptr_d  = do_pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d  = do_push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is deliberately left uncleared by reset; the valid mask gates it.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            rd_mem_q[wr_ptr_q]   <= push_rd;
            data_mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Head view, flattened storage and per-slot occupancy derived from distance to rd_ptr.
    always_comb begin
        head_rd   = empty ? {ADDR_W{1'b0}} : rd_mem_q[rd_ptr_q];
        head_data = empty ? {DATA_W{1'b0}} : data_mem_q[rd_ptr_q];
        offset_s  = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            entry_rd[i*ADDR_W +: ADDR_W]   = rd_mem_q[i];
            entry_data[i*DATA_W +: DATA_W] = data_mem_q[i];
            offset_s                       = PTR_W'(i) - rd_ptr_q;
            valid_mask[i]                  = ({1'b0, offset_s} < count_q);
        end
    end

endmodule

// File: rtl/reg_writeback_queue.sv
// Writeback initiator: arbitrates memory/ALU results into wb_fifo and drains one
// register write per cycle. Pending-result forwarding is built when WB_FORWARD_EN is defined.
module reg_writeback_queue
    import wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = wb_pkg::ADDR_W,
    parameter int DATA_W = wb_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memValid,
    input  logic [ADDR_W-1:0] memRd,
    input  logic [DATA_W-1:0] memData,
    output logic              memReady,
    input  logic              aluValid,
    input  logic [ADDR_W-1:0] aluRd,
    input  logic [DATA_W-1:0] aluData,
    output logic              aluReady,
    input  logic              wbHold,
    output logic              regWrite,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] fwdRs,
    input  logic [ADDR_W-1:0] fwdRt,
    output logic              fwdRsHit,
    output logic [DATA_W-1:0] fwdRsData,
    output logic              fwdRtHit,
    output logic [DATA_W-1:0] fwdRtData
);

    localparam int                PTR_W     = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic                     full_s, empty_s;
    logic                     mem_acc_s, alu_acc_s;
    logic                     push_s, pop_s;
    logic [ADDR_W-1:0]        push_rd_s, head_rd_s;
    logic [DATA_W-1:0]        push_data_s, head_data_s;
    logic [PTR_W-1:0]         wr_ptr_s;
    logic [DEPTH-1:0]         valid_mask_s;
    logic [DEPTH*ADDR_W-1:0]  entry_rd_s;
    logic [DEPTH*DATA_W-1:0]  entry_data_s;

    // Memory wins arbitration; readies look only at registered occupancy so wbHold never reaches them.
    always_comb begin
        memReady    = !rst && !full_s;
        aluReady    = !rst && !full_s && !memValid;
        mem_acc_s   = memValid && memReady;
        alu_acc_s   = aluValid && aluReady;
        push_rd_s   = mem_acc_s ? memRd   : aluRd;
        push_data_s = mem_acc_s ? memData : aluData;
        push_s      = (mem_acc_s || alu_acc_s) && (push_rd_s != ZERO_ADDR);
        regWrite    = !rst && !empty_s && !wbHold;
        pop_s       = regWrite;
        rd          = head_rd_s;
        writeData   = head_data_s;
    end

    wb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .push_rd    (push_rd_s),
        .push_data  (push_data_s),
        .pop        (pop_s),
        .head_rd    (head_rd_s),
        .head_data  (head_data_s),
        .full       (full_s),
        .empty      (empty_s),
        .wr_ptr     (wr_ptr_s),
        .valid_mask (valid_mask_s),
        .entry_rd   (entry_rd_s),
        .entry_data (entry_data_s)
    );

`ifdef WB_FORWARD_EN
    // Walks slots oldest-to-newest ending just behind wr_ptr, so the last match is the newest.
    function automatic logic [DATA_W:0] fwd_lookup(
        input logic [ADDR_W-1:0]       addr,
        input logic [PTR_W-1:0]        wptr,
        input logic [DEPTH-1:0]        valid,
        input logic [DEPTH*ADDR_W-1:0] rds,
        input logic [DEPTH*DATA_W-1:0] datas
    );
        logic [DATA_W:0]  result;
        logic [PTR_W-1:0] idx;
        logic             match;
        result = {(DATA_W+1){1'b0}};
        for (int k = DEPTH; k >= 1; k--) begin
            idx    = wptr - PTR_W'(k);
            match  = valid[idx] && (rds[idx*ADDR_W +: ADDR_W] == addr) && (addr != ZERO_ADDR);
            result = match ? {1'b1, datas[idx*DATA_W +: DATA_W]} : result;
        end
        return result;
    endfunction

    // Forwarding lookups for both source operands.
    always_comb begin
        {fwdRsHit, fwdRsData} = fwd_lookup(fwdRs, wr_ptr_s, valid_mask_s, entry_rd_s, entry_data_s);
        {fwdRtHit, fwdRtData} = fwd_lookup(fwdRt, wr_ptr_s, valid_mask_s, entry_rd_s, entry_data_s);
    end
`else
    logic unused_fwd_s;

    assign unused_fwd_s = ^{fwdRs, fwdRt, wr_ptr_s, valid_mask_s, entry_rd_s, entry_data_s};
    assign fwdRsHit     = 1'b0;
    assign fwdRsData    = {DATA_W{1'b0}};
    assign fwdRtHit     = 1'b0;
    assign fwdRtData    = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench for reg_writeback_queue: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_reg_writeback_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 6;
    localparam int DW    = 32;
`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          memValid, aluValid, wbHold;
    logic [AW-1:0] memRd, aluRd, fwdRs, fwdRt;
    logic [DW-1:0] memData, aluData;
    logic          memReady, aluReady, regWrite, fwdRsHit, fwdRtHit;
    logic [AW-1:0] rd;
    logic [DW-1:0] writeData, fwdRsData, fwdRtData;

    always #5 clk = ~clk;

    reg_writeback_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .memValid(memValid), .memRd(memRd), .memData(memData), .memReady(memReady),
        .aluValid(aluValid), .aluRd(aluRd), .aluData(aluData), .aluReady(aluReady),
        .wbHold(wbHold), .regWrite(regWrite), .rd(rd), .writeData(writeData),
        .fwdRs(fwdRs), .fwdRt(fwdRt),
        .fwdRsHit(fwdRsHit), .fwdRsData(fwdRsData),
        .fwdRtHit(fwdRtHit), .fwdRtData(fwdRtData)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;
    ent_t mq[$];
    bit   model_on = 1'b0;

    typedef struct {
        logic mv; logic [AW-1:0] mrd; logic [DW-1:0] mdata;
        logic av; logic [AW-1:0] ard; logic [DW-1:0] adata;
        logic hold;
        logic e_mr; logic e_ar; logic e_rw; logic [AW-1:0] e_rd; logic [DW-1:0] e_wd;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] mdata,
                          input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] adata,
                          input logic hold);
        memValid = mv; memRd = mrd; memData = mdata;
        aluValid = av; aluRd = ard; aluData = adata;
        wbHold   = hold;
    endtask

    task automatic model_lookup(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        for (int i = 0; i < mq.size(); i++) begin
            if (FWD && a != 0 && mq[i].rd == a) begin
                hit = 1'b1;
                d   = mq[i].data;
            end
        end
    endtask

    task automatic model_check();
        int            n;
        logic          e_mr, e_ar, e_rw, h;
        logic [AW-1:0] e_rd;
        logic [DW-1:0] e_wd, d;
        n    = mq.size();
        e_mr = !rst && (n < DEPTH);
        e_ar = e_mr && !memValid;
        e_rw = !rst && (n > 0) && !wbHold;
        e_rd = (n > 0) ? mq[0].rd : '0;
        e_wd = (n > 0) ? mq[0].data : '0;
        chk("model_memReady", memReady, e_mr);
        chk("model_aluReady", aluReady, e_ar);
        chk("model_regWrite", regWrite, e_rw);
        chk("model_rd", rd, e_rd);
        chk("model_writeData", writeData, e_wd);
        model_lookup(fwdRs, h, d);
        chk("model_fwdRsHit", fwdRsHit, h);
        chk("model_fwdRsData", fwdRsData, d);
        model_lookup(fwdRt, h, d);
        chk("model_fwdRtHit", fwdRtHit, h);
        chk("model_fwdRtData", fwdRtData, d);
    endtask

    task automatic model_update();
        int   n;
        logic mem_acc, alu_acc;
        ent_t e;
        if (rst) begin
            mq.delete();
            model_on = 1'b1;
        end else if (model_on) begin
            n       = mq.size();
            mem_acc = memValid && (n < DEPTH);
            alu_acc = aluValid && (n < DEPTH) && !memValid;
            if ((n > 0) && !wbHold) void'(mq.pop_front());
            e.rd   = mem_acc ? memRd : aluRd;
            e.data = mem_acc ? memData : aluData;
            if ((mem_acc || alu_acc) && e.rd != 0) mq.push_back(e);
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        if (model_on) model_check();
    endtask

    task automatic to_next();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        // mv mrd mdata   av ard adata  hold | mr ar rw rd wd
        vecs[0] = '{0, 0, 0,     1, 5, 32'h2A, 0,  1, 1, 0, 0, 0};
        vecs[1] = '{0, 0, 0,     0, 0, 0,      0,  1, 1, 1, 5, 32'h2A};
        vecs[2] = '{0, 0, 0,     0, 0, 0,      0,  1, 1, 0, 0, 0};
        vecs[3] = '{1, 3, 32'h11, 1, 4, 32'h22, 0,  1, 0, 0, 0, 0};
        vecs[4] = '{0, 0, 0,     1, 4, 32'h22, 0,  1, 1, 1, 3, 32'h11};
        vecs[5] = '{0, 0, 0,     0, 0, 0,      0,  1, 1, 1, 4, 32'h22};
        vecs[6] = '{0, 0, 0,     0, 0, 0,      0,  1, 1, 0, 0, 0};
        vecs[7] = '{0, 0, 0,     1, 0, 32'hFF, 0,  1, 1, 0, 0, 0};
        vecs[8] = '{0, 0, 0,     0, 0, 0,      0,  1, 1, 0, 0, 0};
        vecs[9] = '{0, 0, 0,     0, 0, 0,      0,  1, 1, 0, 0, 0};

        set_in(0, 0, 0, 0, 0, 0, 0);
        fwdRs = '0; fwdRt = '0;
        rst   = 1'b1;
        to_next();
        at_neg();
        chk("rst_memReady", memReady, 0);
        chk("rst_aluReady", aluReady, 0);
        chk("rst_regWrite", regWrite, 0);
        to_next();
        rst = 1'b0;
        at_neg();
        chk("post_rst_regWrite", regWrite, 0);
        chk("post_rst_rd", rd, 0);
        chk("post_rst_writeData", writeData, 0);
        chk("post_rst_fwdRsHit", fwdRsHit, 0);
        chk("post_rst_memReady", memReady, 1);
        to_next();

        for (int i = 0; i < 10; i++) begin
            set_in(vecs[i].mv, vecs[i].mrd, vecs[i].mdata, vecs[i].av, vecs[i].ard, vecs[i].adata, vecs[i].hold);
            at_neg();
            chk($sformatf("vec%0d_memReady", i), memReady, vecs[i].e_mr);
            chk($sformatf("vec%0d_aluReady", i), aluReady, vecs[i].e_ar);
            chk($sformatf("vec%0d_regWrite", i), regWrite, vecs[i].e_rw);
            chk($sformatf("vec%0d_rd", i), rd, vecs[i].e_rd);
            chk($sformatf("vec%0d_writeData", i), writeData, vecs[i].e_wd);
            to_next();
        end

        // Hold with five ALU results: four fill the queue, the fifth stalls.
        for (int n = 1; n <= 5; n++) begin
            set_in(0, 0, 0, 1, AW'(n), 32'h100 + n, 1);
            at_neg();
            chk($sformatf("hold_aluReady_%0d", n), aluReady, (n <= 4) ? 1 : 0);
            chk($sformatf("hold_regWrite_%0d", n), regWrite, 0);
            to_next();
        end
        for (int j = 1; j <= 5; j++) begin
            set_in(0, 0, 0, (j <= 2) ? 1'b1 : 1'b0, 5, 32'h105, 0);
            at_neg();
            if (j == 1) chk("release_full_aluReady", aluReady, 0);
            chk($sformatf("release_regWrite_%0d", j), regWrite, 1);
            chk($sformatf("release_rd_%0d", j), rd, j);
            chk($sformatf("release_data_%0d", j), writeData, 32'h100 + j);
            to_next();
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        at_neg();
        chk("release_drained", regWrite, 0);
        to_next();

        // Forwarding: newest of two pending rd=7 wins; the result being accepted is invisible.
        fwdRs = 7; fwdRt = 8;
        set_in(0, 0, 0, 1, 7, 32'h10, 1);
        at_neg();
        chk("fwd_accepting_hit", fwdRsHit, 0);
        to_next();
        set_in(0, 0, 0, 1, 7, 32'h20, 1);
        at_neg();
        chk("fwd_one_hit", fwdRsHit, FWD);
        chk("fwd_one_data", fwdRsData, FWD ? 32'h10 : 32'h0);
        to_next();
        set_in(0, 0, 0, 1, 12, 32'h30, 1);
        at_neg();
        chk("fwd_newest_hit", fwdRsHit, FWD);
        chk("fwd_newest_data", fwdRsData, FWD ? 32'h20 : 32'h0);
        chk("fwd_miss_hit", fwdRtHit, 0);
        chk("fwd_miss_data", fwdRtData, 0);
        to_next();

        // Reset with three queued entries under hold discards them all.
        set_in(0, 0, 0, 0, 0, 0, 1);
        rst = 1'b1;
        at_neg();
        chk("midrst_regWrite", regWrite, 0);
        chk("midrst_memReady", memReady, 0);
        to_next();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 2; c++) begin
            at_neg();
            chk($sformatf("after_rst_regWrite_%0d", c), regWrite, 0);
            chk($sformatf("after_rst_fwdRsHit_%0d", c), fwdRsHit, 0);
            to_next();
        end

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            set_in($urandom_range(0, 9) < 4, AW'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 9) < 5, AW'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 3) == 0);
            fwdRs = AW'($urandom_range(0, 7));
            fwdRt = AW'($urandom_range(0, 7));
            at_neg();
            to_next();
        end
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 8; c++) begin
            at_neg();
            to_next();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_writeback_queue.md
# reg_writeback_queue

- Write-side initiator for the 64×32 register file.
- Collects results from the ALU and memory-load producers through valid/ready handshakes, buffers them in a small in-order queue, and drives the register file's `regWrite`/`rd`/`writeData` port at one write per cycle.
- The drain can be paused with `wbHold` so another agent (loader/debug) can own the write port.
- Optionally reports pending, not-yet-committed results for source-register forwarding.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, ≥2
- `ADDR_W`, 6: register address width (64 registers)
- `DATA_W`, 32: register data width

Ports:
- `clk` input 1: clock, all state on posedge
- `rst` input 1: reset, synchronous, active-high
- `memValid` input 1: memory-load result valid
- `memRd` input ADDR_W: memory result destination
- `memData` input DATA_W: memory result value
- `memReady` output 1: memory result accepted this edge when high with `memValid`
- `aluValid` input 1: ALU result valid
- `aluRd` input ADDR_W: ALU result destination
- `aluData` input DATA_W: ALU result value
- `aluReady` output 1: ALU result accepted this edge when high with `aluValid`
- `wbHold` input 1: block draining this cycle
- `regWrite` output 1: register file write enable
- `rd` output ADDR_W: register file write address
- `writeData` output DATA_W: register file write data
- `fwdRs` input ADDR_W: forwarding lookup address 1
- `fwdRt` input ADDR_W: forwarding lookup address 2
- `fwdRsHit` output 1: pending entry matches `fwdRs`
- `fwdRsData` output DATA_W: newest pending data for `fwdRs`
- `fwdRtHit` output 1: pending entry matches `fwdRt`
- `fwdRtData` output DATA_W: newest pending data for `fwdRt`

## Operation
- In-order circular queue with `rdPtr`, `wrPtr` (log2 DEPTH bits, wrapping) and `count` (0..DEPTH).
- Arbitration: at most one enqueue per cycle; memory has fixed priority.
  - `memReady = !full`
  - `aluReady = !full && !memValid`
- Both ready signals depend only on registered `count`, not on a same-cycle pop, so there is no combinational path from `wbHold`.
- Results with destination 0 are accepted (ready asserted as usual) but discarded, not enqueued. Register 0 is never written.
- Drain: `regWrite = (count != 0) && !wbHold`. `rd`/`writeData` = head entry, combinational from queue storage. On an edge with `regWrite` high, head pops; the register file commits at the same edge.
- Simultaneous push and pop: `count` unchanged, both pointers advance. When `count == DEPTH` no push occurs (ready low), so a pop only frees a slot.
- Forwarding: search all valid entries; on multiple matches the newest (closest to `wrPtr`) wins. Address 0 never hits. Hit/data are combinational from queue state. The entry being accepted this cycle is not visible.
- When the queue is empty, `rd` = 0 and `writeData` = 0.

## Timing
- Reset values: `count` 0; pointers 0; `regWrite`, `memReady`/`aluReady` low until the cycle after reset deasserts; `rd` 0; `writeData` 0; all fwd hits 0. Storage is not cleared.
- Latency: result accepted at edge N → `regWrite` high in cycle N..N+1 (if not held) → committed at edge N+1. Steady state is one write per cycle.
- Full: `count == DEPTH` → both ready low the entire cycle, even if a pop happens that edge. Ready returns the cycle after the pop.
- Reset mid-operation: all queued writes are discarded with no partial commit; an edge with `rst` high performs no enqueue and no pop.
- `wbHold` held indefinitely: queue fills to DEPTH and producers stall. Order is preserved on release.

## Configuration
- `WB_FORWARD_EN` defined: forwarding search logic is compiled in as described.
- Undefined: `fwdRsHit`/`fwdRtHit` tied 0 and `fwdRsData`/`fwdRtData` tied 0. Ports remain; `fwdRs`/`fwdRt` are ignored.

## Structure
- Shared header/package `wb_pkg`: `ADDR_W`, `DATA_W`, `REG_COUNT` = 64, `ZERO_REG` = 0 constants.
- Sub-module `wb_fifo`: storage, pointers, count, push/pop, full/empty. Exports the entry array and valid mask for the forwarding search.
- Arbitration, zero-drop and forwarding live in the top level.

## Test plan
- ALU only: `aluValid` with rd=5, data=0x2A, empty queue, no hold → `aluReady` 1, next cycle `regWrite` 1 with `rd` 5 and `writeData` 0x2A, then idle.
- Both producers valid, same cycle: mem (rd=3, 0x11) and alu (rd=4, 0x22) → mem accepted first and `aluReady` 0. The following cycle alu is accepted. Writes occur in order 3 then 4.
- `wbHold` = 1 with 5 ALU results (rd 1..5) → 4 accepted, 5th stalls with `aluReady` 0. Release → writes 1,2,3,4,5 on consecutive cycles.
- Zero drop: ALU rd=0, data=0xFF → accepted, `count` stays 0, `regWrite` never high.
- Forwarding (`WB_FORWARD_EN`): hold, enqueue rd=7/0x10 then rd=7/0x20, `fwdRs`=7 → hit 1, data 0x20. `fwdRt`=8 → hit 0. Without the macro both hits are 0.
- Reset with 3 queued entries under hold → `count` 0 next cycle; release hold → no `regWrite`.
